execute_mem_reg: RTL and testbench

//   Y86 execute-stage back end: takes the ALU result (valE) plus E-stage control, computes and holds the

---
 rtl/execute_mem_reg_if.sv | 48 ++++
 rtl/execute_mem_reg.sv | 155 +++++++++++++++
 tb/tb_execute_mem_reg.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_mem_reg_if.sv
// E-stage to M-stage bundle for the Y86 execute back end: E-stage controls and
// operands flow into the block, the condition-code and M-register views flow out.
interface execute_mem_reg_if #(
    parameter int WIDTH = 32
);
    // E-stage side
    logic             e_valid;
    logic [3:0]       e_icode;
    logic [3:0]       e_ifun;
    logic [1:0]       e_op;
    logic [WIDTH-1:0] e_valA;
    logic [WIDTH-1:0] e_valB;
    logic [WIDTH-1:0] e_valE;
    logic [3:0]       e_dstE;
    logic [3:0]       e_dstM;
    logic             e_set_cc;
    logic             cc_inhibit;
    logic             m_stall;
    logic             m_bubble;

    // Results
    logic             e_cnd;
    logic [3:0]       e_dstE_eff;
    logic             zf;
    logic             sf;
    logic             of;
    logic             m_valid;
    logic [3:0]       m_icode;
    logic             m_cnd;
    logic [WIDTH-1:0] m_valE;
    logic [WIDTH-1:0] m_valA;
    logic [3:0]       m_dstE;
    logic [3:0]       m_dstM;

    modport master (
        output e_valid, e_icode, e_ifun, e_op, e_valA, e_valB, e_valE,
               e_dstE, e_dstM, e_set_cc, cc_inhibit, m_stall, m_bubble,
        input  e_cnd, e_dstE_eff, zf, sf, of,
               m_valid, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM
    );

    modport slave (
        input  e_valid, e_icode, e_ifun, e_op, e_valA, e_valB, e_valE,
               e_dstE, e_dstM, e_set_cc, cc_inhibit, m_stall, m_bubble,
        output e_cnd, e_dstE_eff, zf, sf, of,
               m_valid, m_icode, m_cnd, m_valE, m_valA, m_dstE, m_dstM
    );
endinterface

// File: rtl/execute_mem_reg.sv
// Y86 execute-stage back end: condition-code register, jXX/cmovXX condition
// evaluation and the E->M pipeline register.
module execute_mem_reg #(
    parameter int         WIDTH     = 32,
    parameter logic [3:0] REG_NONE  = 4'hF,
    parameter logic [3:0] ICODE_NOP = 4'h1
) (
    input logic               clk,
    input logic               resetn,
    execute_mem_reg_if.slave  bus
);

    localparam logic [3:0] ICODE_CMOV = 4'h2;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_t;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'd0,
        C_LE     = 4'd1,
        C_L      = 4'd2,
        C_E      = 4'd3,
        C_NE     = 4'd4,
        C_GE     = 4'd5,
        C_G      = 4'd6
    } cond_t;

    // Condition-code register
    logic zf_reg, sf_reg, of_reg;
    logic zf_next, sf_next, of_next;
    logic cc_write;

    // E->M pipeline register
    logic             m_valid_reg;
    logic [3:0]       m_icode_reg;
    logic             m_cnd_reg;
    logic [WIDTH-1:0] m_valE_reg;
    logic [WIDTH-1:0] m_valA_reg;
    logic [3:0]       m_dstE_reg;
    logic [3:0]       m_dstM_reg;

    logic       cnd;
    logic [3:0] dste_eff;
    logic       sign_a, sign_b, sign_e;
    logic       lt;

    // Conditions look at the flags already in the register, never at the
    // flags this instruction is about to produce.
    assign lt = sf_reg ^ of_reg;

    always_comb begin
        cnd = 1'b0;
        case (bus.e_ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf_reg;
            C_L:      cnd = lt;
            C_E:      cnd = zf_reg;
            C_NE:     cnd = ~zf_reg;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf_reg;
            default:  cnd = 1'b0;
        endcase
    end

    // A failed cmov still flows down the pipe but must not write a register.
    assign dste_eff = ((bus.e_icode == ICODE_CMOV) && !cnd) ? REG_NONE : bus.e_dstE;

    assign sign_a = bus.e_valA[WIDTH-1];
    assign sign_b = bus.e_valB[WIDTH-1];
    assign sign_e = bus.e_valE[WIDTH-1];

    always_comb begin
        zf_next = (bus.e_valE == '0);
        sf_next = sign_e;
        of_next = 1'b0;
        case (alu_op_t'(bus.e_op))
            ALU_ADD: of_next = (sign_a == sign_b) && (sign_e != sign_a);
            ALU_SUB: of_next = (sign_a != sign_b) && (sign_e != sign_b);
            ALU_AND: of_next = 1'b0;
            ALU_XOR: of_next = 1'b0;
            default: of_next = 1'b0;
        endcase
    end

    // A stalled M stage means the E instruction will be replayed, so its
    // flags must not be committed yet.
    assign cc_write = bus.e_set_cc & bus.e_valid & ~bus.cc_inhibit & ~bus.m_stall;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            zf_reg <= 1'b1;
            sf_reg <= 1'b0;
            of_reg <= 1'b0;
        end else if (cc_write) begin
            zf_reg <= zf_next;
            sf_reg <= sf_next;
            of_reg <= of_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_valid_reg <= 1'b0;
            m_icode_reg <= ICODE_NOP;
            m_cnd_reg   <= 1'b0;
            m_valE_reg  <= '0;
            m_valA_reg  <= '0;
            m_dstE_reg  <= REG_NONE;
            m_dstM_reg  <= REG_NONE;
        end else if (bus.m_stall) begin
            m_valid_reg <= m_valid_reg;
            m_icode_reg <= m_icode_reg;
            m_cnd_reg   <= m_cnd_reg;
            m_valE_reg  <= m_valE_reg;
            m_valA_reg  <= m_valA_reg;
            m_dstE_reg  <= m_dstE_reg;
            m_dstM_reg  <= m_dstM_reg;
        end else if (bus.m_bubble) begin
            m_valid_reg <= 1'b0;
            m_icode_reg <= ICODE_NOP;
            m_cnd_reg   <= 1'b0;
            m_valE_reg  <= '0;
            m_valA_reg  <= '0;
            m_dstE_reg  <= REG_NONE;
            m_dstM_reg  <= REG_NONE;
        end else begin
            // Invalid slots keep their payload for debug but lose their writes.
            m_valid_reg <= bus.e_valid;
            m_icode_reg <= bus.e_icode;
            m_cnd_reg   <= cnd;
            m_valE_reg  <= bus.e_valE;
            m_valA_reg  <= bus.e_valA;
            m_dstE_reg  <= bus.e_valid ? dste_eff   : REG_NONE;
            m_dstM_reg  <= bus.e_valid ? bus.e_dstM : REG_NONE;
        end
    end

    assign bus.e_cnd      = cnd;
    assign bus.e_dstE_eff = dste_eff;
    assign bus.zf         = zf_reg;
    assign bus.sf         = sf_reg;
    assign bus.of         = of_reg;
    assign bus.m_valid    = m_valid_reg;
    assign bus.m_icode    = m_icode_reg;
    assign bus.m_cnd      = m_cnd_reg;
    assign bus.m_valE     = m_valE_reg;
    assign bus.m_valA     = m_valA_reg;
    assign bus.m_dstE     = m_dstE_reg;
    assign bus.m_dstM     = m_dstM_reg;

endmodule

// File: tb/tb_execute_mem_reg.sv
// Bench for execute_mem_reg: directed scenarios plus a randomized run checked
// against a signed-arithmetic reference model of the E->M stage.
module tb_execute_mem_reg;

    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    execute_mem_reg_if #(.WIDTH(W)) bus ();

    execute_mem_reg #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          r_zf, r_sf, r_of;
    bit          r_valid, r_cnd;
    bit [3:0]    r_icode, r_dstE, r_dstM;
    bit [W-1:0]  r_valE, r_valA;

    function automatic bit model_cond(input bit [3:0] ifun);
        bit less = (r_sf != r_of);
        case (ifun)
            4'd0: return 1'b1;
            4'd1: return less || r_zf;
            4'd2: return less;
            4'd3: return r_zf;
            4'd4: return !r_zf;
            4'd5: return !less;
            4'd6: return !less && !r_zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [3:0] model_dst(input bit [3:0] icode, input bit [3:0] ifun,
                                           input bit [3:0] dst);
        return (icode == 4'd2 && !model_cond(ifun)) ? 4'hF : dst;
    endfunction

    // Overflow means the true signed result does not fit in W bits.
    function automatic bit model_of(input bit [1:0] op, input bit [W-1:0] a, input bit [W-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        if (op == 2'd0)      r = sb + sa;
        else if (op == 2'd1) r = sb - sa;
        else                 return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic bit [W-1:0] alu(input bit [1:0] op, input bit [W-1:0] a, input bit [W-1:0] b);
        case (op)
            2'd0: return b + a;
            2'd1: return b - a;
            2'd2: return b & a;
            default: return b ^ a;
        endcase
    endfunction

    task automatic drive(input bit valid, input bit [3:0] icode, input bit [3:0] ifun,
                         input bit [1:0] op, input bit [W-1:0] a, input bit [W-1:0] b,
                         input bit [3:0] dste, input bit [3:0] dstm, input bit set_cc,
                         input bit inh, input bit stall, input bit bubble);
        bus.e_valid = valid;  bus.e_icode = icode;  bus.e_ifun = ifun;  bus.e_op = op;
        bus.e_valA = a;  bus.e_valB = b;  bus.e_valE = alu(op, a, b);
        bus.e_dstE = dste;  bus.e_dstM = dstm;  bus.e_set_cc = set_cc;
        bus.cc_inhibit = inh;  bus.m_stall = stall;  bus.m_bubble = bubble;
    endtask

    // One clock edge: the model takes the same step the stage should take.
    task automatic advance();
        bit c;
        bit [3:0] eff;
        @(posedge clk);
        if (!resetn) begin
            {r_zf, r_sf, r_of} = 3'b100;
            r_valid = 0; r_icode = 4'h1; r_cnd = 0; r_valE = '0; r_valA = '0;
            r_dstE = 4'hF; r_dstM = 4'hF;
        end else begin
            c   = model_cond(bus.e_ifun);
            eff = model_dst(bus.e_icode, bus.e_ifun, bus.e_dstE);
            if (bus.e_set_cc && bus.e_valid && !bus.cc_inhibit && !bus.m_stall) begin
                r_zf = (bus.e_valE == 0);
                r_sf = bus.e_valE[W-1];
                r_of = model_of(bus.e_op, bus.e_valA, bus.e_valB);
            end
            if (bus.m_stall) begin
                // hold everything
            end else if (bus.m_bubble) begin
                r_valid = 0; r_icode = 4'h1; r_cnd = 0; r_valE = '0; r_valA = '0;
                r_dstE = 4'hF; r_dstM = 4'hF;
            end else begin
                r_valid = bus.e_valid; r_icode = bus.e_icode; r_cnd = c;
                r_valE = bus.e_valE; r_valA = bus.e_valA;
                r_dstE = bus.e_valid ? eff : 4'hF;
                r_dstM = bus.e_valid ? bus.e_dstM : 4'hF;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1, 4'h6, 4'h0, 2'd1, 32'h5, 32'h5, 4'h2, 4'h3, 1, 0, 1, 1);
        advance();
        vectors++; if (bus.zf !== 1'b1) begin miscompares++; $display("FAIL reset_zf got %0b want 1", bus.zf); end
        vectors++; if (bus.sf !== 1'b0 || bus.of !== 1'b0) begin miscompares++; $display("FAIL reset_sf_of got %0b%0b want 00", bus.sf, bus.of); end
        vectors++; if (bus.m_icode !== 4'h1 || bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_icode_valid got %h/%0b want 1/0", bus.m_icode, bus.m_valid); end
        vectors++; if (bus.m_dstE !== 4'hF || bus.m_dstM !== 4'hF) begin miscompares++; $display("FAIL reset_m_dst got %h/%h want F/F", bus.m_dstE, bus.m_dstM); end
        vectors++; if (bus.m_valE !== 32'h0 || bus.m_valA !== 32'h0 || bus.m_cnd !== 1'b0) begin miscompares++; $display("FAIL reset_m_data got %h/%h/%0b want 0/0/0", bus.m_valE, bus.m_valA, bus.m_cnd); end
        $display("reset: zf=%0b m_icode=%h m_valid=%0b", bus.zf, bus.m_icode, bus.m_valid);
        resetn = 1'b1;
    endtask

    task automatic test_add_overflow();
        drive(1, 4'h6, 4'h0, 2'd0, 32'h7FFFFFFF, 32'h1, 4'h2, 4'hF, 1, 0, 0, 0);
        advance();
        vectors++; if ({bus.zf, bus.sf, bus.of} !== 3'b011) begin miscompares++; $display("FAIL add_ovf_cc got %0b%0b%0b want 011", bus.zf, bus.sf, bus.of); end
        vectors++; if (bus.m_valE !== 32'h80000000) begin miscompares++; $display("FAIL add_ovf_valE got %h want 80000000", bus.m_valE); end
        vectors++; if (bus.m_dstE !== 4'h2 || bus.m_valid !== 1'b1 || bus.m_icode !== 4'h6) begin miscompares++; $display("FAIL add_ovf_m got dstE=%h v=%0b ic=%h want 2/1/6", bus.m_dstE, bus.m_valid, bus.m_icode); end
        $display("add_overflow: zf=%0b sf=%0b of=%0b m_valE=%h", bus.zf, bus.sf, bus.of, bus.m_valE);
    endtask

    task automatic test_back_to_back();
        // OPl sub writes ZF on its edge; the following jXX must see it at once.
        drive(1, 4'h6, 4'h1, 2'd1, 32'h5, 32'h5, 4'h4, 4'hF, 1, 0, 0, 0);
        advance();
        drive(1, 4'h7, 4'h3, 2'd0, 32'h0, 32'h0, 4'hF, 4'hF, 0, 0, 0, 0);
        #1;
        vectors++; if (bus.e_cnd !== 1'b1) begin miscompares++; $display("FAIL jxx_je got %0b want 1", bus.e_cnd); end
        bus.e_ifun = 4'h4;
        #1;
        vectors++; if (bus.e_cnd !== 1'b0) begin miscompares++; $display("FAIL jxx_jne got %0b want 0", bus.e_cnd); end
        bus.e_ifun = 4'h3;
        advance();
        vectors++; if (bus.m_cnd !== 1'b1 || bus.m_icode !== 4'h7) begin miscompares++; $display("FAIL jxx_m_cnd got %0b/%h want 1/7", bus.m_cnd, bus.m_icode); end
        $display("back_to_back: sub 5-5 then je m_cnd=%0b", bus.m_cnd);
    endtask

    task automatic test_cmov();
        drive(1, 4'h6, 4'h0, 2'd0, 32'h1, 32'h1, 4'h5, 4'hF, 1, 0, 0, 0);
        advance();
        drive(1, 4'h2, 4'h1, 2'd0, 32'h1234, 32'h0, 4'h3, 4'hF, 0, 0, 0, 0);
        #1;
        vectors++; if (bus.e_cnd !== 1'b0 || bus.e_dstE_eff !== 4'hF) begin miscompares++; $display("FAIL cmovle_squash got cnd=%0b eff=%h want 0/F", bus.e_cnd, bus.e_dstE_eff); end
        advance();
        vectors++; if (bus.m_dstE !== 4'hF || bus.m_valA !== 32'h1234) begin miscompares++; $display("FAIL cmovle_m got dstE=%h valA=%h want F/1234", bus.m_dstE, bus.m_valA); end
        drive(1, 4'h2, 4'h0, 2'd0, 32'h9, 32'h0, 4'h3, 4'hF, 0, 0, 0, 0);
        #1;
        vectors++; if (bus.e_dstE_eff !== 4'h3) begin miscompares++; $display("FAIL rrmovl_eff got %h want 3", bus.e_dstE_eff); end
        advance();
        $display("cmov: squashed cmovle, rrmovl m_dstE=%h", bus.m_dstE);
    endtask

    task automatic test_stall();
        bit [2:0]  cc0  = {r_zf, r_sf, r_of};
        bit [3:0]  ic0  = r_icode;
        bit [W-1:0] ve0 = r_valE;
        bit [3:0]  de0  = r_dstE;
        drive(1, 4'h6, 4'h1, 2'd1, 32'h7, 32'h7, 4'h6, 4'h7, 1, 0, 1, 0);
        advance();
        vectors++; if ({bus.zf, bus.sf, bus.of} !== cc0) begin miscompares++; $display("FAIL stall_cc got %b want %b", {bus.zf, bus.sf, bus.of}, cc0); end
        vectors++; if (bus.m_icode !== ic0 || bus.m_valE !== ve0 || bus.m_dstE !== de0) begin miscompares++; $display("FAIL stall_m got %h/%h/%h want %h/%h/%h", bus.m_icode, bus.m_valE, bus.m_dstE, ic0, ve0, de0); end
        bus.m_bubble = 1'b1;
        advance();
        vectors++; if (bus.m_icode !== ic0 || bus.m_valid !== 1'b1 || bus.m_dstE !== de0) begin miscompares++; $display("FAIL stall_bubble got ic=%h v=%0b dstE=%h want %h/1/%h", bus.m_icode, bus.m_valid, bus.m_dstE, ic0, de0); end
        $display("stall: m_icode=%h held, cc=%b held", bus.m_icode, {bus.zf, bus.sf, bus.of});
    endtask

    task automatic test_inhibit_bubble();
        bit [2:0] cc0 = {r_zf, r_sf, r_of};
        drive(1, 4'h6, 4'h1, 2'd1, 32'h3, 32'h3, 4'h1, 4'hF, 1, 1, 0, 0);
        advance();
        vectors++; if ({bus.zf, bus.sf, bus.of} !== cc0) begin miscompares++; $display("FAIL inhibit_cc got %b want %b", {bus.zf, bus.sf, bus.of}, cc0); end
        vectors++; if (bus.m_icode !== 4'h6 || bus.m_dstE !== 4'h1) begin miscompares++; $display("FAIL inhibit_m got %h/%h want 6/1", bus.m_icode, bus.m_dstE); end
        drive(1, 4'h6, 4'h0, 2'd0, 32'h3, 32'h3, 4'h1, 4'h2, 0, 0, 0, 1);
        advance();
        vectors++; if (bus.m_icode !== 4'h1 || bus.m_valid !== 1'b0 || bus.m_dstE !== 4'hF || bus.m_dstM !== 4'hF) begin miscompares++; $display("FAIL bubble_m got ic=%h v=%0b %h/%h want 1/0/F/F", bus.m_icode, bus.m_valid, bus.m_dstE, bus.m_dstM); end
        $display("inhibit_bubble: cc=%b m_icode=%h", {bus.zf, bus.sf, bus.of}, bus.m_icode);
    endtask

    task automatic test_invalid();
        bit [2:0] cc0 = {r_zf, r_sf, r_of};
        drive(0, 4'h6, 4'h0, 2'd1, 32'hA, 32'hA, 4'h4, 4'h5, 1, 0, 0, 0);
        advance();
        vectors++; if (bus.m_dstE !== 4'hF || bus.m_dstM !== 4'hF || bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL invalid_dst got %h/%h v=%0b want F/F/0", bus.m_dstE, bus.m_dstM, bus.m_valid); end
        vectors++; if (bus.m_valA !== 32'hA || bus.m_icode !== 4'h6) begin miscompares++; $display("FAIL invalid_fields got %h/%h want A/6", bus.m_valA, bus.m_icode); end
        vectors++; if ({bus.zf, bus.sf, bus.of} !== cc0) begin miscompares++; $display("FAIL invalid_cc got %b want %b", {bus.zf, bus.sf, bus.of}, cc0); end
        $display("invalid: m_dstE=%h m_dstM=%h", bus.m_dstE, bus.m_dstM);
    endtask

    task automatic test_random(input int n);
        int bad0 = miscompares;
        for (int i = 0; i < n; i++) begin
            bit [3:0]   ic;
            bit [1:0]   op;
            bit [W-1:0] a, b;
            case ($urandom_range(0, 3))
                0: ic = 4'h2;
                1: ic = 4'h6;
                2: ic = 4'h7;
                default: ic = 4'($urandom);
            endcase
            op = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: begin a = 32'($urandom_range(0, 3)); b = 32'h7FFFFFFF - 32'($urandom_range(0, 2)); end
                2: begin a = 32'h80000000; b = 32'($urandom_range(0, 3)); end
                default: ;
            endcase
            resetn = ($urandom_range(0, 63) != 0);
            drive($urandom_range(0, 7) != 0, ic, 4'($urandom_range(0, 8)), op, a, b,
                  4'($urandom), 4'($urandom), (ic == 4'h6) || ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            #1;
            vectors++; if (bus.e_cnd !== model_cond(bus.e_ifun)) begin miscompares++; $display("FAIL rand_cnd[%0d] got %0b want %0b", i, bus.e_cnd, model_cond(bus.e_ifun)); end
            vectors++; if (bus.e_dstE_eff !== model_dst(bus.e_icode, bus.e_ifun, bus.e_dstE)) begin miscompares++; $display("FAIL rand_eff[%0d] got %h want %h", i, bus.e_dstE_eff, model_dst(bus.e_icode, bus.e_ifun, bus.e_dstE)); end
            advance();
            vectors++; if ({bus.zf, bus.sf, bus.of} !== {r_zf, r_sf, r_of}) begin miscompares++; $display("FAIL rand_cc[%0d] got %b want %b", i, {bus.zf, bus.sf, bus.of}, {r_zf, r_sf, r_of}); end
            vectors++; if (bus.m_valid !== r_valid || bus.m_icode !== r_icode || bus.m_cnd !== r_cnd) begin miscompares++; $display("FAIL rand_mctl[%0d] got %0b/%h/%0b want %0b/%h/%0b", i, bus.m_valid, bus.m_icode, bus.m_cnd, r_valid, r_icode, r_cnd); end
            vectors++; if (bus.m_valE !== r_valE || bus.m_valA !== r_valA) begin miscompares++; $display("FAIL rand_mdata[%0d] got %h/%h want %h/%h", i, bus.m_valE, bus.m_valA, r_valE, r_valA); end
            vectors++; if (bus.m_dstE !== r_dstE || bus.m_dstM !== r_dstM) begin miscompares++; $display("FAIL rand_mdst[%0d] got %h/%h want %h/%h", i, bus.m_dstE, bus.m_dstM, r_dstE, r_dstM); end
        end
        resetn = 1'b1;
        $display("random: %0d cycles, %0d new miscompares", n, miscompares - bad0);
    endtask

    initial begin
        drive(0, 4'h1, 4'h0, 2'd0, '0, '0, 4'hF, 4'hF, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_cmov();
        test_stall();
        test_inhibit_bubble();
        test_invalid();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
